// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM states and
// the reset-time constants used by the fetch stage.
package pipeline_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit (65 bits) with
// write-enable, flush and bubble-load control.
module if_id_reg import pipeline_pkg::*; #(
  parameter logic [31:0] BUBBLE = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic        flush,
  input  logic        bubble,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q, pc4_q;
  logic        valid_q;

  // Flush wins over write_en; a bubble keeps the previous PC+4.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= BUBBLE;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush || (write_en && bubble)) begin
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (write_en) begin
      instr_q <= next_instr;
      pc4_q   <= next_pc4;
      valid_q <= 1'b1;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory and feeds the IF/ID register.
module fetch_stage import pipeline_pkg::*; #(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_Write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PC4,
  output logic        ID_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, skid_q, skid_d, pc_plus4, ifid_instr;
  logic         kill_q, kill_d, ifid_load;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_req  = (state_q == REQ) && !reset;
  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      skid_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    skid_d     = skid_q;
    ifid_load  = 1'b0;
    ifid_instr = imem_rdata;
    unique case (state_q)
      REQ: begin
        if (imem_ready) begin
          state_d = WAIT;
          // Request already accepted at the old PC: its response must die.
          kill_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (ID_Write) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
            state_d   = REQ;
          end else begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (ID_Write) begin
          ifid_load  = 1'b1;
          ifid_instr = skid_q;
          pc_d       = pc_plus4;
          state_d    = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    if (redirect_valid) pc_d = word_align(redirect_pc);
  end

  if_id_reg #(
    .BUBBLE(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .write_en  (ID_Write),
    .flush     (redirect_valid),
    .bubble    (!ifid_load),
    .next_instr(ifid_instr),
    .next_pc4  (pc_plus4),
    .instr     (ID_Instr),
    .pc4       (ID_PC4),
    .valid     (ID_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a transaction-level model
// predicts per-cycle outputs, a separate monitor pops and compares them.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int          NCYC   = 4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ID_Write = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ID_Instr;
  logic [31:0] ID_PC4;
  logic        ID_valid;

  fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ID_Write      (ID_Write),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .ID_Instr      (ID_Instr),
    .ID_PC4        (ID_PC4),
    .ID_valid      (ID_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_now = 0;

  // Reference model: a fetch is either being requested, outstanding (maybe
  // doomed by a redirect) or fetched-and-waiting for ID to accept it.
  logic [31:0] m_pc, m_held, m_instr, m_pc4;
  logic        m_out, m_doom, m_have, m_valid;

  // Memory model: at most one response pending, delivered after a delay.
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_now, act, req);
    end
  endtask

  task automatic model_step(input logic rst, input logic idw, input logic redir,
                            input logic [31:0] rpc, input logic rdy, input logic rv,
                            input logic [31:0] rd);
    logic requesting, got, avail;
    logic [31:0] ainstr;
    requesting = !m_out && !m_have;
    got        = m_out && rv;
    avail      = 1'b0;
    ainstr     = 32'h0;
    if (rst) begin
      m_pc = RST_PC; m_out = 0; m_doom = 0; m_have = 0;
      m_instr = NOP; m_pc4 = 32'h0; m_valid = 0;
      return;
    end
    if (got && !m_doom) begin
      avail = 1'b1; ainstr = rd;
    end else if (m_have) begin
      avail = 1'b1; ainstr = m_held;
    end
    if (redir) begin
      m_instr = NOP; m_valid = 1'b0;
      if (requesting && rdy) begin
        m_out = 1'b1; m_doom = 1'b1;
      end else if (got) begin
        m_out = 1'b0; m_doom = 1'b0;
      end else if (m_out) begin
        m_doom = 1'b1;
      end
      m_have = 1'b0;
      m_pc   = rpc & 32'hFFFF_FFFC;
    end else begin
      if (requesting && rdy) m_out = 1'b1;
      else if (got) begin
        m_out = 1'b0; m_doom = 1'b0;
      end
      if (avail) begin
        if (idw) begin
          m_pc4 = m_pc + 32'd4; m_instr = ainstr; m_valid = 1'b1;
          m_pc  = m_pc + 32'd4; m_have = 1'b0;
        end else begin
          m_have = 1'b1; m_held = ainstr;
        end
      end else if (idw) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
  endtask

  // Driver: choose inputs, advance the model, queue the expected outputs.
  initial begin
    logic rst_v, idw, redir, redir_prev, rdy, rv, requesting;
    logic [31:0] rpc, rd;
    redir_prev = 1'b0;
    m_pc = RST_PC; m_out = 0; m_doom = 0; m_have = 0; m_held = 32'h0;
    m_instr = NOP; m_pc4 = 32'h0; m_valid = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      cyc_now = cyc;
      rst_v = (cyc < 2) || ($urandom_range(0, 249) == 0);
      rv = 1'b0;
      rd = $urandom;
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          rv = 1'b1; rd = mem_data; mem_pend = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      rdy   = !mem_pend && !rv && ($urandom_range(0, 9) < 6);
      idw   = ($urandom_range(0, 3) != 0);
      redir = !rst_v && !redir_prev && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFFD;
        default: rpc = 32'h0000_0040 | 32'($urandom_range(0, 3));
      endcase
      redir_prev = redir;
      requesting = !m_out && !m_have;
      if (!rst_v && requesting && rdy) begin
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(0, 2);
        mem_data = $urandom;
      end
      reset          = rst_v;
      ID_Write       = idw;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_ready     = rdy;
      imem_rvalid    = rv;
      imem_rdata     = rd;
      model_step(rst_v, idw, redir, rpc, rdy, rv, rd);
      exp_q.push_back('{req: !rst_v && !m_out && !m_have, addr: m_pc, instr: m_instr,
                        pc4: m_pc4, valid: m_valid});
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compare DUT outputs away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_req", 32'(imem_req), 32'(e.req));
        chk("imem_addr", imem_addr, e.addr);
        chk("ID_Instr", ID_Instr, e.instr);
        chk("ID_PC4", ID_PC4, e.pc4);
        chk("ID_valid", 32'(ID_valid), 32'(e.valid));
      end
    end
  end

endmodule
